digital_output_sequencer: RTL

//  Drives 2 chained SN74HC595 shift registers (SER/SRCLK/RCLK/OE_n) to set 16 digital outputs on the extension board.

---
 rtl/digital_output_sequencer_if.sv | 24 ++
 rtl/digital_output_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/digital_output_sequencer_if.sv
// Signal bundle between the output sequencer, its 1-bit pin-value memory port
// and the SN74HC595 chain.
`timescale 1ns/1ps
interface digital_output_sequencer_if;
  logic       enable;
  logic [5:0] address;
  logic       read_data;
  logic       sr_data;
  logic       sr_clock;
  logic       sr_latch;
  logic       sr_oe_n;
  logic       busy;
  logic       frame_done;

  modport master (
    input  enable, read_data,
    output address, sr_data, sr_clock, sr_latch, sr_oe_n, busy, frame_done
  );

  modport slave (
    output enable, read_data,
    input  address, sr_data, sr_clock, sr_latch, sr_oe_n, busy, frame_done
  );
endinterface

// File: rtl/digital_output_sequencer.sv
// Shifts NUMBER_OF_OUTPUTS memory bits (MSB first) into chained 595s, then pulses RCLK once per frame.
// Optional macro DOUT_SEQ_OE_BLANK_EN holds OE_n high until the first complete frame is latched.
`timescale 1ns/1ps
module digital_output_sequencer #(
  parameter int SR_CLK_DIVIDER      = 1000,
  parameter int INPUT_ADDRESS_START = 32,
  parameter int NUMBER_OF_OUTPUTS   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  digital_output_sequencer_if.master   bus
);
  localparam int               HALF        = SR_CLK_DIVIDER / 2;
  localparam int               CNT_W       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CAPTURE_CNT = CNT_W'(1);
  localparam logic [4:0]       IDX_TOP     = 5'(NUMBER_OF_OUTPUTS - 1);
  localparam logic [5:0]       ADDR_BASE   = 6'(INPUT_ADDRESS_START);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LATCH, GAP} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] div_cnt_reg;
  logic [4:0]       idx_reg;
  logic [5:0]       address_reg;
  logic             sr_data_reg;
  logic             sr_clock_reg;
  logic             sr_latch_reg;
  logic             busy_reg;
  logic             frame_done_reg;
  logic             tick;

  assign tick = (div_cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // States always change on tick, so the divider count doubles as the cycle-in-state index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      address_reg    <= ADDR_BASE;
      sr_data_reg    <= 1'b0;
      sr_clock_reg   <= 1'b0;
      sr_latch_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      // Memory answers one cycle after the address moves, i.e. in the second SETUP cycle.
      if (state_reg == SETUP && div_cnt_reg == CAPTURE_CNT) begin
        sr_data_reg <= bus.read_data;
      end
      if (tick) begin
        unique case (state_reg)
          IDLE: begin
            if (bus.enable) begin
              state_reg   <= SETUP;
              idx_reg     <= IDX_TOP;
              address_reg <= ADDR_BASE + {1'b0, IDX_TOP};
              busy_reg    <= 1'b1;
            end
          end
          SETUP: begin
            state_reg    <= HIGH;
            sr_clock_reg <= 1'b1;
          end
          HIGH: begin
            sr_clock_reg <= 1'b0;
            if (idx_reg == 5'd0) begin
              state_reg    <= LATCH;
              sr_latch_reg <= 1'b1;
            end else begin
              state_reg   <= SETUP;
              idx_reg     <= idx_reg - 5'd1;
              address_reg <= ADDR_BASE + {1'b0, idx_reg - 5'd1};
            end
          end
          LATCH: begin
            state_reg    <= GAP;
            sr_latch_reg <= 1'b0;
          end
          GAP: begin
            frame_done_reg <= 1'b1;
            if (bus.enable) begin
              state_reg   <= SETUP;
              idx_reg     <= IDX_TOP;
              address_reg <= ADDR_BASE + {1'b0, IDX_TOP};
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg    <= IDLE;
            sr_clock_reg <= 1'b0;
            sr_latch_reg <= 1'b0;
            busy_reg     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DOUT_SEQ_OE_BLANK_EN
  logic sr_oe_n_reg;

  // Outputs stay blanked until a full frame has overwritten the power-up contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_oe_n_reg <= 1'b1;
    end else if (tick && state_reg == LATCH) begin
      sr_oe_n_reg <= 1'b0;
    end
  end

  assign bus.sr_oe_n = sr_oe_n_reg;
`else
  assign bus.sr_oe_n = 1'b0;
`endif

  assign bus.address    = address_reg;
  assign bus.sr_data    = sr_data_reg;
  assign bus.sr_clock   = sr_clock_reg;
  assign bus.sr_latch   = sr_latch_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;
endmodule
